gray_counter_ud: RTL and testbench
==================================

# gray_counter_ud

Parametrised up/down Gray-code counter with synchronous load, a binary mirror output, a zero-crossing pulse and a built-in single-bit-change checker. It is the general successor to the fixed 12-bit, up-only Gray counter. It serves as the pointer/sequence source for clock-domain-crossing FIFOs and for formal liveness benches. All outputs are registered and aligned: no lag between binary and Gray views.

## Interface
- `WIDTH`, default 12: counter width in bits, legal range 2..32.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst_n`  in  1  reset, synchronous, active-low, sampled on `clk` rising edge.
- `en`  in  1  count enable; one step per cycle while high.
- `dir`  in  1  count direction: 1 = up, 0 = down.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  binary value to load.
- `bin_cnt`  out  WIDTH  registered binary count.
- `gray_cnt`  out  WIDTH  registered Gray count; always equals bin_cnt ^ (bin_cnt >> 1).
- `sig`  out  1  one-cycle pulse: a count step has just landed on zero.
- `err`  out  1  sticky flag: a count step changed other than exactly one Gray bit.

## Operation
- Priority per cycle: `rst_n`=0 > `load`=1 > `en`=1 > hold.
- Reset: `bin_cnt`=0, `gray_cnt`=0, `sig`=0, `err`=0.
- Load:
  - `bin_cnt`=`load_val` and `gray_cnt`=bin2gray(`load_val`).
  - `sig`=0, even when `load_val`=0.
  - The checker is skipped this cycle.
  - `en`/`dir` are ignored.
- Count step with `en`=1:
  - Up: `bin_cnt` ← (`bin_cnt`+1) mod 2^WIDTH.
  - Down: `bin_cnt` ← (`bin_cnt`−1) mod 2^WIDTH.
  - Arithmetic is WIDTH bits; carry/borrow is discarded.
- Wrap-around:
  - Up from 2^WIDTH−1 (Gray 100…0) → 0.
  - Down from 0 → 2^WIDTH−1 (Gray 100…0).
  - Both are single-bit Gray changes.
- `sig`:
  - High for exactly the cycle in which `gray_cnt`==0 as the result of a count step, in either direction.
  - Low in hold, load and reset cycles.
  - Holding at 0 after a step gives one pulse only.
- `err`:
  - On each count step, the checker compares the previous and next `gray_cnt`.
  - `err` sets if their XOR has popcount ≠ 1.
  - Once set, it stays set until reset.
  - The checker works from the Gray registers only, never from `bin_cnt`, so it independently observes the datapath.
- Direction change between consecutive steps is legal and still yields single-bit changes.

## Timing
- Latency: control sampled at edge N; `bin_cnt`, `gray_cnt` and `sig` are updated after edge N.
- `err` asserts after the same edge as the offending step.
- Full-rate counting: `en` held high gives one step per cycle; there is no handshake and no backpressure.
- Reset mid-count: the next edge forces all outputs to zero regardless of `load`/`en`.
- `load` and `en` high together: the load wins and no step occurs.
- The first count step after a load is checked against the loaded Gray value.
- No combinational path from inputs to outputs.

## Structure
- Package `gray_pkg` holds:
  - function `bin2gray(WIDTH)`;
  - function `gray2bin(WIDTH)` (prefix-XOR);
  - function `onehot_diff` (XOR popcount == 1);
  - `localparam GRAY_MAX_WIDTH = 32`.
- One sub-module `gray_step_checker #(WIDTH)`:
  - inputs: `clk`, `rst_n`, `step_valid`, `gray_prev`, `gray_next`;
  - output: sticky `err`.
  - It is reused by the CDC FIFO pointer logic.
- The top level holds the binary register, the next-state mux and the `sig` register.

## Test plan
- Reset then `en`=1, `dir`=1 for 2^WIDTH cycles (WIDTH=4) → Gray sequence 0,1,3,2,6,…,8 then 0; `sig`=1 only on the cycle `gray_cnt` returns to 0; `err`=0 throughout.
- Reset, `en`=1, `dir`=0 for 3 cycles (WIDTH=4) → `bin_cnt` 15,14,13; `gray_cnt` 8,9,11; `sig` stays 0.
- `load`=1 with `load_val`=1, then `dir`=0 and `en`=1 for one cycle → `gray_cnt` 1 then 0, `sig` pulses once; repeat with `load_val`=0 → `sig` stays 0.
- `load` and `en` both high with `load_val`=5 (WIDTH=4) → `bin_cnt`=5, `gray_cnt`=7, no step taken, `err` unchanged.
- Counting up, drop `rst_n` for one cycle with `load`=1 → all outputs 0 after that edge; `sig`=0.
- Fault injection (force `gray_cnt` bit 2 during a step) → `err` rises that cycle and stays high until `rst_n`=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the up/down counter and the CDC FIFO pointer logic.
// Functions work on GRAY_MAX_WIDTH-bit values; narrower callers zero-extend.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs decode correctly.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic onehot_diff(input logic [GRAY_MAX_WIDTH-1:0] a,
                                       input logic [GRAY_MAX_WIDTH-1:0] b);
    logic [GRAY_MAX_WIDTH-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - 1)) == '0);
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Sticky monitor that flags any Gray step changing other than exactly one bit.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_valid,
  input  logic [WIDTH-1:0] gray_prev,
  input  logic [WIDTH-1:0] gray_next,
  output logic             err
);

  logic step_ok;

  always_comb begin
    step_ok = onehot_diff(GRAY_MAX_WIDTH'(gray_prev), GRAY_MAX_WIDTH'(gray_next));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (step_valid && !step_ok) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_counter_ud.sv
// Parametrised up/down Gray counter with load, aligned binary mirror,
// zero-landing pulse and an independent single-bit-change checker.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_cnt,
  output logic [WIDTH-1:0] gray_cnt,
  output logic             sig,
  output logic             err
);

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             step;

  always_comb begin
    step     = en && !load;
    bin_next = bin_cnt;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      bin_next = dir ? bin_cnt + 1'b1 : bin_cnt - 1'b1;
    end
    gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
  end

  // Gray is its own register so the checker sees the real Gray state, not a decode of bin_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_cnt  <= '0;
      gray_cnt <= '0;
      sig      <= 1'b0;
    end else begin
      bin_cnt  <= bin_next;
      gray_cnt <= gray_next;
      sig      <= step && (gray_next == '0);
    end
  end

  gray_step_checker #(
    .WIDTH(WIDTH)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_valid(step),
    .gray_prev (gray_cnt),
    .gray_next (gray_next),
    .err       (err)
  );

endmodule

// File: tb/tb_gray_counter_ud.sv
// Table-driven scoreboard bench for gray_counter_ud at WIDTH=4.
module tb_gray_counter_ud;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] bin_cnt;
  logic [W-1:0] gray_cnt;
  logic         sig;
  logic         err;

  always #5 clk = ~clk;

  gray_counter_ud #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .bin_cnt (bin_cnt),
    .gray_cnt(gray_cnt),
    .sig     (sig),
    .err     (err)
  );

  typedef struct {
    logic         rst_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         dir;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         sig;
  } vec_t;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         sig;
    logic         err;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [W-1:0] model_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    g[W-1] = b[W-1];
    return g;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      compare("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      compare({e.name, ".bin"}, 32'(bin_cnt), 32'(e.bin));
      compare({e.name, ".gray"}, 32'(gray_cnt), 32'(e.gray));
      compare({e.name, ".sig"}, 32'(sig), 32'(e.sig));
      compare({e.name, ".err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input logic exp_err, input string name);
    exp_t e;
    @(negedge clk);
    rst_n    = v.rst_n;
    load     = v.load;
    load_val = v.load_val;
    en       = v.en;
    dir      = v.dir;
    e.bin  = v.bin;
    e.gray = v.gray;
    e.sig  = v.sig;
    e.err  = exp_err;
    e.name = name;
    sb_q.push_back(e);
    check_output();
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // rst_n, load, load_val, en, dir, exp bin, exp gray, exp sig
    vecs.push_back('{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd0,  4'd0,  1'b0}); // reset
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'd8,  1'b0}); // down wrap
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd14, 4'd9,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd13, 4'd11, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd1,  1'b0, 1'b0, 4'd1,  4'd1,  1'b0}); // load 1
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  4'd0,  1'b1}); // step to 0
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0}); // hold at 0
    vecs.push_back('{1'b1, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  4'd0,  1'b0}); // load 0, en ignored
    vecs.push_back('{1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 4'd5,  4'd7,  1'b0}); // load beats en
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  4'd5,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  4'd7,  1'b0}); // dir change
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd6,  4'd5,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 4'd0,  4'd0,  1'b0}); // reset beats load
    vecs.push_back('{1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 4'd8,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'd0,  1'b1}); // up wrap
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 4'd0,  4'd0,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'd8,  1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Full up sweep from reset, expectations from the bench's own Gray model.
    v = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
    apply_stimulus(v, 1'b0, "sweep_reset");
    for (int i = 1; i <= 16; i++) begin
      logic [W-1:0] b;
      b = W'(i);
      v = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, b, model_gray(b), (b == '0)};
      apply_stimulus(v, 1'b0, $sformatf("sweep%0d", i));
    end

    // Corrupt the Gray register so the next step differs in two bits.
    v = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0};
    apply_stimulus(v, 1'b0, "inj_load");
    @(negedge clk);
    force dut.gray_cnt = 4'b0101;
    load = 1'b0;
    en   = 1'b1;
    dir  = 1'b1;
    @(posedge clk);
    #1;
    release dut.gray_cnt;
    compare("inj_err_rise", 32'(err), 32'd1);
    compare("inj_bin", 32'(bin_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = (i == 1);
      @(posedge clk);
      #1;
      compare($sformatf("inj_err_sticky%0d", i), 32'(err), 32'd1);
    end
    v = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
    apply_stimulus(v, 1'b0, "inj_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
